multicycle_core: RTL and testbench

Parametrised multicycle MIPS-subset processor core: a fetch/decode/execute/memory/writeback FSM with an internal register file and a single-port, variable-latency memory handshake. It supersedes the fixed-width stage sequencer and sits between the instruction/data memory model and the top-level testbench. It adds configurable datapath and address widths, memory wait states, loads/stores/branches, and explicit halt and trap states.

---
 rtl/multicycle_core_if.sv | 23 ++
 rtl/multicycle_core.sv | 195 +++++++++++++++++++
 tb/tb_multicycle_core.sv | 388 ++++++++++++++++++++++++++++++++++++++
 3 files changed

// File: rtl/multicycle_core_if.sv
// Single-port memory handshake between the core (master) and the instruction/data memory (slave).
// The request holds address and data stable until mem_ack; mem_ack is only meaningful while mem_req is high.
interface multicycle_core_if #(
  parameter int WIDTH      = 32,
  parameter int ADDR_WIDTH = 10
);
  logic                  mem_req;
  logic                  mem_we;
  logic [ADDR_WIDTH-1:0] mem_addr;
  logic [WIDTH-1:0]      mem_wdata;
  logic [WIDTH-1:0]      mem_rdata;
  logic                  mem_ack;

  modport master (
    output mem_req, mem_we, mem_addr, mem_wdata,
    input  mem_rdata, mem_ack
  );

  modport slave (
    input  mem_req, mem_we, mem_addr, mem_wdata,
    output mem_rdata, mem_ack
  );
endinterface

// File: rtl/multicycle_core.sv
// Multicycle MIPS-subset core: IFETCH/DECODE/EXECUTE/MEMORY/WRITEBACK with sticky HALT/TRAP.
// Zero-wait latency 3 (BEQ/J), 4 (ALU, SW), 5 (LW); each memory wait cycle stalls the FSM by one.
module multicycle_core #(
  parameter int WIDTH      = 32,
  parameter int ADDR_WIDTH = 10,
  parameter int NREGS      = 32
) (
  input  logic                  clk,
  input  logic                  rst_n,
  multicycle_core_if.master     mem,
  input  logic [4:0]            dbg_sel,
  output logic [WIDTH-1:0]      dbg_data,
  output logic [2:0]            stage,
  output logic [ADDR_WIDTH-1:0] pc,
  output logic                  halted,
  output logic                  trap
);
  localparam int IDXW = $clog2(NREGS);

  localparam logic [5:0] OP_RTYPE = 6'h00;
  localparam logic [5:0] OP_J     = 6'h02;
  localparam logic [5:0] OP_BEQ   = 6'h04;
  localparam logic [5:0] OP_ADDI  = 6'h08;
  localparam logic [5:0] OP_LW    = 6'h23;
  localparam logic [5:0] OP_SW    = 6'h2B;
  localparam logic [5:0] OP_HALT  = 6'h3F;

  localparam logic [5:0] F_ADD  = 6'h20;
  localparam logic [5:0] F_ADDU = 6'h21;
  localparam logic [5:0] F_SUB  = 6'h22;
  localparam logic [5:0] F_SUBU = 6'h23;
  localparam logic [5:0] F_AND  = 6'h24;
  localparam logic [5:0] F_OR   = 6'h25;
  localparam logic [5:0] F_SLT  = 6'h2A;

  typedef enum logic [2:0] {
    S_IFETCH    = 3'd0,
    S_DECODE    = 3'd1,
    S_EXECUTE   = 3'd2,
    S_MEMORY    = 3'd3,
    S_WRITEBACK = 3'd4,
    S_HALT      = 3'd5,
    S_TRAP      = 3'd6
  } state_t;

  state_t                state;
  logic [31:0]           ir;
  logic [WIDTH-1:0]      a_r, b_r, res_r;
  logic [ADDR_WIDTH-1:0] addr_r;
  logic [WIDTH-1:0]      regs [NREGS];

  logic [5:0]            opcode, funct;
  logic [IDXW-1:0]       rs_idx, rt_idx, rd_idx, wb_idx;
  logic [WIDTH-1:0]      imm_sx, sum_ab, dif_ab, sum_ai, alu_res;
  logic                  ovf_add, ovf_sub, ovf_ai, alu_ovf, legal;
  logic [ADDR_WIDTH-1:0] br_tgt, j_tgt;

  assign opcode = ir[31:26];
  assign funct  = ir[5:0];
  assign rs_idx = ir[21 +: IDXW];
  assign rt_idx = ir[16 +: IDXW];
  assign rd_idx = ir[11 +: IDXW];
  assign wb_idx = (opcode == OP_RTYPE) ? rd_idx : rt_idx;
  assign imm_sx = {{(WIDTH-16){ir[15]}}, ir[15:0]};

  assign sum_ab  = a_r + b_r;
  assign dif_ab  = a_r - b_r;
  assign sum_ai  = a_r + imm_sx;
  assign ovf_add = (a_r[WIDTH-1] == b_r[WIDTH-1])    && (sum_ab[WIDTH-1] != a_r[WIDTH-1]);
  assign ovf_sub = (a_r[WIDTH-1] != b_r[WIDTH-1])    && (dif_ab[WIDTH-1] != a_r[WIDTH-1]);
  assign ovf_ai  = (a_r[WIDTH-1] == imm_sx[WIDTH-1]) && (sum_ai[WIDTH-1] != a_r[WIDTH-1]);

  // pc already points past the branch when EXECUTE evaluates these targets.
  assign br_tgt = pc + ADDR_WIDTH'({imm_sx, 2'b00});
  assign j_tgt  = ADDR_WIDTH'({ir[25:0], 2'b00});

  always_comb begin
    legal = 1'b0;
    case (opcode)
      OP_RTYPE: begin
        case (funct)
          F_ADD, F_ADDU, F_SUB, F_SUBU, F_AND, F_OR, F_SLT: legal = 1'b1;
          default: legal = 1'b0;
        endcase
      end
      OP_ADDI, OP_LW, OP_SW, OP_BEQ, OP_J: legal = 1'b1;
      default: legal = 1'b0;
    endcase
  end

  always_comb begin
    alu_res = '0;
    alu_ovf = 1'b0;
    if (opcode == OP_RTYPE) begin
      case (funct)
        F_ADD:   begin alu_res = sum_ab; alu_ovf = ovf_add; end
        F_ADDU:  alu_res = sum_ab;
        F_SUB:   begin alu_res = dif_ab; alu_ovf = ovf_sub; end
        F_SUBU:  alu_res = dif_ab;
        F_AND:   alu_res = a_r & b_r;
        F_OR:    alu_res = a_r | b_r;
        F_SLT:   alu_res = {{(WIDTH-1){1'b0}}, ($signed(a_r) < $signed(b_r))};
        default: alu_res = '0;
      endcase
    end else if (opcode == OP_ADDI) begin
      alu_res = sum_ai;
      alu_ovf = ovf_ai;
    end
  end

  assign mem.mem_req   = (state == S_IFETCH) || (state == S_MEMORY);
  assign mem.mem_we    = (state == S_MEMORY) && (opcode == OP_SW);
  assign mem.mem_addr  = (state == S_IFETCH) ? pc : addr_r;
  assign mem.mem_wdata = b_r;

  assign stage    = state;
  assign dbg_data = regs[dbg_sel[IDXW-1:0]];

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state  <= S_IFETCH;
      pc     <= '0;
      ir     <= '0;
      a_r    <= '0;
      b_r    <= '0;
      res_r  <= '0;
      addr_r <= '0;
      halted <= 1'b0;
      trap   <= 1'b0;
      for (int i = 0; i < NREGS; i++) regs[i] <= '0;
    end else begin
      case (state)
        S_IFETCH: begin
          if (mem.mem_ack) begin
            ir    <= mem.mem_rdata[31:0];
            pc    <= pc + ADDR_WIDTH'(4);
            state <= S_DECODE;
          end
        end
        S_DECODE: begin
          a_r <= regs[rs_idx];
          b_r <= regs[rt_idx];
          if (opcode == OP_HALT) begin
            state  <= S_HALT;
            halted <= 1'b1;
          end else if (!legal) begin
            state <= S_TRAP;
            trap  <= 1'b1;
          end else begin
            state <= S_EXECUTE;
          end
        end
        S_EXECUTE: begin
          res_r  <= alu_res;
          addr_r <= ADDR_WIDTH'(sum_ai);
          case (opcode)
            OP_LW, OP_SW: state <= S_MEMORY;
            OP_BEQ: begin
              if (a_r == b_r) pc <= br_tgt;
              state <= S_IFETCH;
            end
            OP_J: begin
              pc    <= j_tgt;
              state <= S_IFETCH;
            end
            default: begin
              // An overflowing ADD/SUB/ADDI never reaches the register file.
              if (alu_ovf) begin
                state <= S_TRAP;
                trap  <= 1'b1;
              end else begin
                state <= S_WRITEBACK;
              end
            end
          endcase
        end
        S_MEMORY: begin
          if (mem.mem_ack) begin
            if (opcode == OP_SW) begin
              state <= S_IFETCH;
            end else begin
              res_r <= mem.mem_rdata;
              state <= S_WRITEBACK;
            end
          end
        end
        S_WRITEBACK: begin
          if (wb_idx != '0) regs[wb_idx] <= res_r;
          state <= S_IFETCH;
        end
        default: state <= state;
      endcase
    end
  end
endmodule

// File: tb/tb_multicycle_core.sv
// Bench for multicycle_core: instruction-level model expands each instruction into its expected
// per-cycle stage/pc/memory trace; a 64-bit, 8-register build is exercised separately.
module tb_multicycle_core;
  logic        clk = 1'b0;
  logic        rst_n = 1'b0;
  logic        rst2_n = 1'b0;
  logic [4:0]  dbg_sel = 5'd0;
  logic [4:0]  dbg_sel2 = 5'd0;
  logic [31:0] dbg_data;
  logic [63:0] dbg_data2;
  logic [2:0]  stage, stage2;
  logic [9:0]  pc, pc2;
  logic        halted, trap, halted2, trap2;

  int          n_chk = 0;
  int          n_fail = 0;
  bit          chk_en = 1'b0;
  bit          load_req = 1'b0;
  bit          ack_any = 1'b0;
  int          wait_n = 0;
  int          cnt = 0;
  int          hc, n40, nwe, n8;

  logic [31:0] prog  [256];
  logic [31:0] mem   [256];
  logic [31:0] prog2 [256];
  logic [31:0] mmem  [256];
  logic [31:0] mregs [32];

  typedef struct {
    logic [2:0]  stage;
    logic [9:0]  pc;
    logic        req;
    logic        we;
    logic [9:0]  addr;
    logic [31:0] wdata;
  } exp_t;
  exp_t exp_q[$];

  multicycle_core_if #(.WIDTH(32), .ADDR_WIDTH(10)) mif ();
  multicycle_core_if #(.WIDTH(64), .ADDR_WIDTH(10)) mif2 ();

  multicycle_core #(.WIDTH(32), .ADDR_WIDTH(10), .NREGS(32)) dut (
    .clk(clk), .rst_n(rst_n), .mem(mif), .dbg_sel(dbg_sel), .dbg_data(dbg_data),
    .stage(stage), .pc(pc), .halted(halted), .trap(trap)
  );

  multicycle_core #(.WIDTH(64), .ADDR_WIDTH(10), .NREGS(8)) dut2 (
    .clk(clk), .rst_n(rst2_n), .mem(mif2), .dbg_sel(dbg_sel2), .dbg_data(dbg_data2),
    .stage(stage2), .pc(pc2), .halted(halted2), .trap(trap2)
  );

  always #5 clk = ~clk;

  // Memory with wait_n wait cycles per access; ack_any also raises ack while no request is open.
  always @(posedge clk) begin
    if (load_req) begin
      for (int i = 0; i < 256; i++) mem[i] <= prog[i];
      cnt <= 0;
    end else if (mif.mem_req && mif.mem_ack) begin
      cnt <= 0;
      if (mif.mem_we) mem[mif.mem_addr[9:2]] <= mif.mem_wdata;
    end else if (mif.mem_req) begin
      cnt <= cnt + 1;
    end else begin
      cnt <= 0;
    end
  end
  assign mif.mem_ack   = ack_any | (mif.mem_req && (cnt >= wait_n));
  assign mif.mem_rdata = mem[mif.mem_addr[9:2]];
  assign mif2.mem_ack   = mif2.mem_req;
  assign mif2.mem_rdata = {32'hDEADBEEF, prog2[mif2.mem_addr[9:2]]};

  function automatic void chk(input string name, input logic [63:0] got, input logic [63:0] expv);
    n_chk++;
    if (got !== expv) begin
      n_fail++;
      $display("FAIL %s: got %0h, expected %0h (t=%0t)", name, got, expv, $time);
    end
  endfunction

  function automatic logic [31:0] enc_i(input logic [5:0] op, input logic [4:0] rs, input logic [4:0] rt,
                                        input logic [15:0] imm);
    return {op, rs, rt, imm};
  endfunction
  function automatic logic [31:0] enc_r(input logic [4:0] rs, input logic [4:0] rt, input logic [4:0] rd,
                                        input logic [5:0] fn);
    return {6'h00, rs, rt, rd, 5'h00, fn};
  endfunction
  localparam logic [31:0] HALT_W = 32'hFC00_0000;

  function automatic bit legal(input logic [5:0] op, input logic [5:0] fn);
    if (op == 6'h00) return fn inside {6'h20, 6'h21, 6'h22, 6'h23, 6'h24, 6'h25, 6'h2A};
    return op inside {6'h08, 6'h23, 6'h2B, 6'h04, 6'h02};
  endfunction

  function automatic void push(input logic [2:0] st, input logic [9:0] p, input logic rq, input logic w,
                               input logic [9:0] a, input logic [31:0] d);
    exp_t e;
    e.stage = st; e.pc = p; e.req = rq; e.we = w; e.addr = a; e.wdata = d;
    exp_q.push_back(e);
  endfunction

  function automatic bit ovf32(input longint s);
    return (s > 64'sd2147483647) || (s < -64'sd2147483648);
  endfunction

  // Instruction-set interpreter producing the cycle-by-cycle trace for memory latency w.
  task automatic build_trace(input int w, input int max_instr);
    logic [9:0]  mpc, npc, ea;
    logic [31:0] ins, a, b, r, sx, t;
    logic [5:0]  op, fn;
    int          dst;
    bit          wr, ovf;
    longint      s;
    exp_q.delete();
    for (int i = 0; i < 32; i++) mregs[i] = 32'd0;
    for (int i = 0; i < 256; i++) mmem[i] = prog[i];
    mpc = 10'd0;
    for (int n = 0; n < max_instr; n++) begin
      ins = mmem[mpc[9:2]];
      repeat (w + 1) push(3'd0, mpc, 1'b1, 1'b0, mpc, 32'd0);
      npc = mpc + 10'd4;
      op = ins[31:26]; fn = ins[5:0];
      sx = {{16{ins[15]}}, ins[15:0]};
      push(3'd1, npc, 1'b0, 1'b0, 10'd0, 32'd0);
      if (op == 6'h3F) begin push(3'd5, npc, 1'b0, 1'b0, 10'd0, 32'd0); return; end
      if (!legal(op, fn)) begin push(3'd6, npc, 1'b0, 1'b0, 10'd0, 32'd0); return; end
      push(3'd2, npc, 1'b0, 1'b0, 10'd0, 32'd0);
      a = mregs[ins[25:21]]; b = mregs[ins[20:16]];
      wr = 1'b0; ovf = 1'b0; r = 32'd0; dst = 0;
      t = a + sx; ea = t[9:0];
      case (op)
        6'h00: begin
          wr = 1'b1; dst = int'(ins[15:11]);
          case (fn)
            6'h20: begin s = longint'($signed(a)) + longint'($signed(b)); ovf = ovf32(s); r = a + b; end
            6'h21: r = a + b;
            6'h22: begin s = longint'($signed(a)) - longint'($signed(b)); ovf = ovf32(s); r = a - b; end
            6'h23: r = a - b;
            6'h24: r = a & b;
            6'h25: r = a | b;
            default: r = ($signed(a) < $signed(b)) ? 32'd1 : 32'd0;
          endcase
        end
        6'h08: begin
          s = longint'($signed(a)) + longint'($signed(sx)); ovf = ovf32(s);
          r = t; wr = 1'b1; dst = int'(ins[20:16]);
        end
        6'h23: begin
          repeat (w + 1) push(3'd3, npc, 1'b1, 1'b0, ea, 32'd0);
          r = mmem[ea[9:2]]; wr = 1'b1; dst = int'(ins[20:16]);
        end
        6'h2B: begin
          repeat (w + 1) push(3'd3, npc, 1'b1, 1'b1, ea, b);
          mmem[ea[9:2]] = b;
        end
        6'h04: if (a == b) npc = npc + {sx[7:0], 2'b00};
        default: npc = {ins[7:0], 2'b00};
      endcase
      if (ovf) begin push(3'd6, npc, 1'b0, 1'b0, 10'd0, 32'd0); return; end
      if (wr) begin
        push(3'd4, npc, 1'b0, 1'b0, 10'd0, 32'd0);
        if (dst != 0) mregs[dst] = r;
      end
      mpc = npc;
    end
  endtask

  // Per-cycle comparison against the model trace; a terminal HALT/TRAP entry is held (sticky).
  initial begin
    exp_t e;
    forever begin
      @(negedge clk);
      if (chk_en && exp_q.size() > 0) begin
        e = exp_q[0];
        if (exp_q.size() > 1 || e.stage < 3'd5) void'(exp_q.pop_front());
        chk("trace_stage", stage, e.stage);
        chk("trace_pc", pc, e.pc);
        chk("trace_mem_req", mif.mem_req, e.req);
        chk("trace_halted", halted, e.stage == 3'd5);
        chk("trace_trap", trap, e.stage == 3'd6);
        if (e.req) begin
          chk("trace_mem_addr", mif.mem_addr, e.addr);
          chk("trace_mem_we", mif.mem_we, e.we);
          if (e.we) chk("trace_mem_wdata", mif.mem_wdata, e.wdata);
        end
      end
    end
  end

  task automatic clear_prog();
    for (int i = 0; i < 256; i++) prog[i] = 32'd0;
  endtask

  task automatic do_reset(input bit en);
    chk_en = 1'b0;
    rst_n = 1'b0; load_req = 1'b1;
    @(posedge clk); #1;
    rst_n = 1'b1; load_req = 1'b0;
    chk_en = en;
  endtask

  task automatic run(input int n);
    hc = 0; n40 = 0; nwe = 0; n8 = 0;
    for (int i = 1; i <= n; i++) begin
      @(negedge clk);
      if (hc == 0 && (halted || trap)) hc = i;
      if (mif.mem_req && mif.mem_addr == 10'h040) n40++;
      if (mif.mem_req && mif.mem_we) nwe++;
      if (stage == 3'd0 && pc == 10'd8) n8++;
    end
    chk_en = 1'b0;
  endtask

  task automatic rd(input int idx, output logic [31:0] v);
    dbg_sel = 5'(idx); #1; v = dbg_data;
  endtask

  task automatic check_model_regs(input string tag);
    logic [31:0] v;
    for (int i = 0; i < 32; i++) begin
      rd(i, v);
      chk({tag, "_reg"}, v, mregs[i]);
    end
  endtask

  task automatic rd2(input int idx, output logic [63:0] v);
    dbg_sel2 = 5'(idx); #1; v = dbg_data2;
  endtask

  initial begin
    #2_000_000;
    $display("FAIL watchdog: simulation did not finish, time %0t", $time);
    $fatal(1);
  end

  initial begin
    logic [31:0] v;
    logic [63:0] v2;
    int          len;
    for (int i = 0; i < 256; i++) prog2[i] = 32'd0;
    @(negedge clk);

    // A: zero-wait arithmetic; ack held high even with no request open.
    clear_prog();
    prog[0] = enc_i(6'h08, 5'd0, 5'd1, 16'd5);
    prog[1] = enc_i(6'h08, 5'd0, 5'd2, 16'd7);
    prog[2] = enc_r(5'd1, 5'd2, 5'd3, 6'h20);
    prog[3] = HALT_W;
    wait_n = 0; ack_any = 1'b1;
    build_trace(0, 100); len = exp_q.size();
    chk("A_model_len", len, 15);
    chk("A_model_r3", mregs[3], 32'd12);
    do_reset(1'b1);
    run(len + 4);
    chk("A_halt_cycle", hc, 15);
    chk("A_pc", pc, 10'd16);
    rd(3, v); chk("A_r3", v, 32'd12);
    chk("A_halted", halted, 1'b1);
    check_model_regs("A");
    @(negedge clk);

    // B: three wait cycles per access, store then load back.
    clear_prog();
    prog[0] = enc_i(6'h08, 5'd0, 5'd3, 16'd12);
    prog[1] = enc_i(6'h2B, 5'd0, 5'd3, 16'h0040);
    prog[2] = enc_i(6'h23, 5'd0, 5'd4, 16'h0040);
    prog[3] = HALT_W;
    wait_n = 3; ack_any = 1'b0;
    build_trace(3, 100); len = exp_q.size();
    do_reset(1'b1);
    for (int i = 1; i <= 3; i++) begin rd(i, v); chk("B_reset_reg", v, 32'd0); end
    chk("B_reset_pc", pc, 10'd0);
    run(len + 4);
    rd(4, v); chk("B_r4", v, 32'd12);
    chk("B_addr40_cycles", n40, 8);
    chk("B_we_cycles", nwe, 4);
    check_model_regs("B");
    @(negedge clk);

    // C: ADDU wraps, R0 stays zero, ADD overflow traps without writeback.
    clear_prog();
    prog[32] = 32'h7FFF_FFFF;
    prog[0] = enc_i(6'h23, 5'd0, 5'd1, 16'h0080);
    prog[1] = enc_i(6'h08, 5'd0, 5'd2, 16'd1);
    prog[2] = enc_r(5'd1, 5'd2, 5'd5, 6'h21);
    prog[3] = enc_i(6'h08, 5'd0, 5'd0, 16'd9);
    prog[4] = enc_r(5'd1, 5'd2, 5'd6, 6'h20);
    wait_n = 0;
    build_trace(0, 100); len = exp_q.size();
    do_reset(1'b1);
    run(len + 4);
    rd(5, v); chk("C_addu", v, 32'h8000_0000);
    rd(0, v); chk("C_r0", v, 32'd0);
    rd(6, v); chk("C_add_ovf_rd", v, 32'd0);
    chk("C_trap", trap, 1'b1);
    chk("C_pc", pc, 10'd20);
    check_model_regs("C");
    @(negedge clk);

    // D: untaken BEQ, J to the top of the address space, HALT there wraps pc.
    clear_prog();
    prog[0] = enc_i(6'h08, 5'd0, 5'd1, 16'd1);
    prog[1] = enc_i(6'h08, 5'd0, 5'd2, 16'd2);
    prog[2] = enc_i(6'h04, 5'd1, 5'd2, 16'd5);
    prog[3] = {6'h02, 26'h3FF_FFFF};
    prog[255] = HALT_W;
    build_trace(0, 100); len = exp_q.size();
    do_reset(1'b1);
    run(len + 4);
    chk("D_halted", halted, 1'b1);
    chk("D_pc_wrap", pc, 10'd0);
    @(negedge clk);

    // E: BEQ r1,r1,-1 at pc 8 loops on itself.
    clear_prog();
    prog[0] = enc_i(6'h08, 5'd0, 5'd1, 16'd1);
    prog[1] = enc_i(6'h08, 5'd0, 5'd2, 16'd2);
    prog[2] = enc_i(6'h04, 5'd1, 5'd1, 16'hFFFF);
    build_trace(0, 7); len = exp_q.size();
    chk("E_model_len", len, 23);
    do_reset(1'b1);
    run(len);
    chk("E_fetches_at_8", n8, 5);
    chk("E_no_halt", hc, 0);
    @(negedge clk);

    // F: unsupported funct traps and stops requesting memory.
    clear_prog();
    prog[0] = enc_r(5'd0, 5'd0, 5'd0, 6'h3E);
    build_trace(0, 100); len = exp_q.size();
    do_reset(1'b1);
    run(len + 6);
    chk("F_trap_cycle", hc, 3);
    chk("F_stage", stage, 3'd6);
    chk("F_mem_req", mif.mem_req, 1'b0);
    chk("F_pc", pc, 10'd4);
    @(negedge clk);

    // G: reset while an LW waits for its ack.
    clear_prog();
    prog[0] = enc_i(6'h08, 5'd0, 5'd1, 16'd3);
    prog[1] = enc_i(6'h23, 5'd0, 5'd2, 16'h0080);
    prog[32] = 32'h0000_ABCD;
    wait_n = 3;
    do_reset(1'b0);
    for (int i = 0; i < 50 && stage != 3'd3; i++) @(negedge clk);
    chk("G_reached_memory", stage, 3'd3);
    rd(1, v); chk("G_r1_before", v, 32'd3);
    rst_n = 1'b0;
    @(posedge clk); #1; rst_n = 1'b1;
    @(negedge clk);
    chk("G_stage", stage, 3'd0);
    chk("G_pc", pc, 10'd0);
    chk("G_mem_req", mif.mem_req, 1'b1);
    chk("G_halted", halted, 1'b0);
    chk("G_trap", trap, 1'b0);
    rd(1, v); chk("G_r1_cleared", v, 32'd0);
    repeat (8) @(negedge clk);
    rd(2, v); chk("G_r2_untouched", v, 32'd0);

    // H: 64-bit datapath, 8 registers.
    prog2[0] = enc_i(6'h08, 5'd0, 5'd1, 16'hFFFF);
    prog2[1] = enc_i(6'h08, 5'd0, 5'd2, 16'd1);
    prog2[2] = enc_r(5'd1, 5'd2, 5'd3, 6'h2A);
    prog2[3] = enc_r(5'd2, 5'd1, 5'd4, 6'h2A);
    prog2[4] = HALT_W;
    rst2_n = 1'b0;
    @(posedge clk); #1; rst2_n = 1'b1;
    for (int i = 0; i < 60 && !halted2; i++) @(negedge clk);
    chk("H_halted", halted2, 1'b1);
    rd2(1, v2); chk("H_r1_minus1", v2, 64'hFFFF_FFFF_FFFF_FFFF);
    rd2(3, v2); chk("H_slt_m1_1", v2, 64'd1);
    rd2(4, v2); chk("H_slt_1_m1", v2, 64'd0);
    prog2[4] = enc_i(6'h08, 5'd0, 5'd9, 16'h0055);
    prog2[5] = HALT_W;
    rst2_n = 1'b0;
    @(posedge clk); #1; rst2_n = 1'b1;
    for (int i = 0; i < 60 && !halted2; i++) @(negedge clk);
    rd2(1, v2); chk("H_alias_r1", v2, 64'h55);
    rd2(9, v2); chk("H_alias_r9", v2, 64'h55);
    chk("H_pc", pc2, 10'd24);

    $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
    $finish;
  end
endmodule
